mini_imem_ctrl: RTL
===================

// Module: mini_imem_ctrl
// PURPOSE
//  Parametrised, writable instruction memory for the mini CPU. After reset it
//  images a built-in boot program into RAM, then serves fetches with a
//  request/valid handshake and 1-cycle registered read latency. A program-load
//  mode lets a host overwrite any word at run time.
// PARAMETERS
//  IW        16    instruction width, format {op[3:0],rd[1:0],rs[1:0],imm[7:0]}
//  AW        8     address width; must satisfy 2**AW >= DEPTH
//  DEPTH     256   number of instruction words
//  BOOT_LEN  7     boot-program words; words BOOT_LEN..DEPTH-1 are imaged as NOP
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous reset, active high
//  fetch_req    in   1    fetch request, accepted when fetch_ready=1
//  fetch_addr   in   AW   fetch word address
//  fetch_ready  out  1    1 only in RUN
//  fetch_valid  out  1    1-cycle pulse, the cycle after an accepted fetch
//  fetch_data   out  IW   fetched instruction; holds value between fetches
//  fetch_err    out  1    valid with fetch_valid: address >= DEPTH
//  prog_en      in   1    request/hold program-load mode
//  prog_we      in   1    write strobe, honoured only in LOAD
//  prog_addr    in   AW   write address
//  prog_data    in   IW   write data
//  busy         out  1    1 in INIT or LOAD
//  boot_done    out  1    1 once INIT has completed; cleared by reset
// BEHAVIOUR
//  - Reset values: fetch_valid=0, fetch_err=0, fetch_data=NOP (16'h0000),
//    fetch_ready=0, busy=1, boot_done=0, state=INIT, init counter=0.
//  - FSM: INIT -> RUN -> LOAD -> RUN.
//    INIT: each cycle writes mem[cnt] = boot_rom(cnt) for cnt<BOOT_LEN, else NOP.
//          cnt increments. After writing cnt=DEPTH-1, go to RUN and set boot_done.
//          INIT lasts exactly DEPTH cycles.
//    RUN:  fetch_ready=1. If prog_en=1, go to LOAD at the next edge.
//    LOAD: if prog_we=1 and prog_addr<DEPTH, write mem[prog_addr]=prog_data.
//          If prog_addr>=DEPTH, drop the write silently.
//          If prog_en=0, go to RUN at the next edge. A prog_we in that same
//          cycle is still honoured.
//  - Fetch: accepted iff fetch_req and fetch_ready. At the next edge:
//    fetch_valid=1, and fetch_data=mem[fetch_addr], or NOP with fetch_err=1
//    when fetch_addr>=DEPTH.
//    With no accepted fetch: fetch_valid=0, fetch_err=0, fetch_data holds.
//  - fetch_req while not ready (INIT/LOAD): ignored, not queued. Requester re-issues.
//  - prog_en and fetch_req together in RUN: the fetch is accepted and returns
//    the pre-load word; state enters LOAD next cycle.
//  - prog_we in INIT or RUN: ignored.
//  - Reset at any point, including mid-INIT or mid-LOAD: restart INIT. RAM is
//    re-imaged, so loaded programs are lost. Any pending fetch_valid is dropped.
//  - No read/write collision is possible: writes occur only in INIT/LOAD,
//    reads only in RUN.
// STRUCTURE
//  - mini_cpu_pkg: opcode constants OP_LDI=4'h1, OP_ADD=4'h2, OP_XOR=4'h4,
//    OP_LD=4'h5, OP_ST=4'h6, OP_JMP=4'h7.
//  - mini_cpu_pkg also holds: instruction field widths/offsets, NOP=16'h0000,
//    and the state encoding (INIT/RUN/LOAD).
//  - Sub-module mini_imem_boot_rom: combinational addr -> word boot image:
//    0:1005 1:1403 2:2100 3:6010 4:5810 5:4900 6:7002, others NOP.
//  - Top: FSM, init counter, single-port RAM array (write mux INIT/LOAD),
//    registered read path.
// TESTING
//  1 Reset, wait DEPTH cycles -> boot_done=1, busy=0.
//    Then fetch 0..7 -> 1005,1403,2100,6010,5810,4900,7002,0000, each
//    with fetch_valid one cycle after request.
//  2 fetch_req during INIT (cycle 10) -> no fetch_valid.
//    fetch_addr=8'hFF with DEPTH=200 -> fetch_valid=1, fetch_err=1, data=0000.
//  3 prog_en=1, write addr 3 = 16'hABCD, prog_en=0.
//    Fetch 3 -> ABCD. Fetch 4 -> 5810 (unchanged).
//  4 prog_en=1 and fetch_req addr 3 same cycle -> fetch returns 6010, busy=1
//    next cycle. fetch_req during LOAD -> no fetch_valid.
//  5 Assert rst at INIT cycle 100, and again after a LOAD write to addr 0.
//    Each time INIT restarts and takes a full DEPTH cycles. Fetch 0 -> 1005.
//  6 prog_we in RUN to addr 1 -> fetch 1 still 1403.
//    LOAD write to prog_addr>=DEPTH -> no RAM word changes.

Source files
------------

// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU: opcodes, instruction fields, imem FSM states.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package mini_cpu_pkg;

  // Opcodes
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;

  // Instruction layout: {op[3:0], rd[1:0], rs[1:0], imm[7:0]}
  localparam int INSN_W  = 16;
  localparam int OP_W    = 4;
  localparam int RD_W    = 2;
  localparam int RS_W    = 2;
  localparam int IMM_W   = 8;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS_LSB  = 8;
  localparam int IMM_LSB = 0;

  localparam logic [INSN_W-1:0] NOP = 16'h0000;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_LOAD = 2'd2
  } imem_state_t;

  function automatic logic [INSN_W-1:0] mk_insn(input logic [OP_W-1:0]  op,
                                               input logic [RD_W-1:0]  rd,
                                               input logic [RS_W-1:0]  rs,
                                               input logic [IMM_W-1:0] imm);
    return {op, rd, rs, imm};
  endfunction

endpackage

// File: rtl/mini_imem_boot_rom.sv
// Built-in boot program image: combinational word address -> instruction.
// Latency: 0 cycles (pure combinational lookup).
// Backpressure: none; always answers.
// Ports: addr (AW) word address in; word (IW) boot instruction out, NOP past the program.
module mini_imem_boot_rom
  import mini_cpu_pkg::*;
#(
  parameter int IW = 16,
  parameter int AW = 8
) (
  input  logic [AW-1:0] addr,
  output logic [IW-1:0] word
);

  always_comb begin
    word = IW'(NOP);
    case (addr)
      AW'(0): word = IW'(mk_insn(OP_LDI, 2'd0, 2'd0, 8'h05)); // 1005
      AW'(1): word = IW'(mk_insn(OP_LDI, 2'd1, 2'd0, 8'h03)); // 1403
      AW'(2): word = IW'(mk_insn(OP_ADD, 2'd0, 2'd1, 8'h00)); // 2100
      AW'(3): word = IW'(mk_insn(OP_ST,  2'd0, 2'd0, 8'h10)); // 6010
      AW'(4): word = IW'(mk_insn(OP_LD,  2'd2, 2'd0, 8'h10)); // 5810
      AW'(5): word = IW'(mk_insn(OP_XOR, 2'd2, 2'd1, 8'h00)); // 4900
      AW'(6): word = IW'(mk_insn(OP_JMP, 2'd0, 2'd0, 8'h02)); // 7002
      default: word = IW'(NOP);
    endcase
  end

endmodule

// File: rtl/mini_imem_ctrl.sv
// Writable instruction memory: boot-images RAM after reset, serves fetches, host program-load.
// Latency: fetch data/valid registered, 1 cycle after an accepted request.
// Backpressure: fetch_ready=0 during INIT/LOAD; requests then are dropped, not queued.
// Ports: clk, rst (sync, active high); fetch_req/fetch_addr in, fetch_ready/fetch_valid/
//        fetch_data/fetch_err out; prog_en/prog_we/prog_addr/prog_data in; busy/boot_done out.
module mini_imem_ctrl
  import mini_cpu_pkg::*;
#(
  parameter int IW       = 16,
  parameter int AW       = 8,   // 2**AW must cover DEPTH
  parameter int DEPTH    = 256,
  parameter int BOOT_LEN = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_ready,
  output logic          fetch_valid,
  output logic [IW-1:0] fetch_data,
  output logic          fetch_err,
  input  logic          prog_en,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  output logic          busy,
  output logic          boot_done
);

  imem_state_t   state_q, state_d;
  logic [AW-1:0] cnt_q;
  logic          init_last;
  logic [IW-1:0] rom_word;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [IW-1:0] mem_wdata;
  logic          fetch_acc;
  logic          fetch_in_range;
  logic          prog_in_range;

  logic [IW-1:0] mem [DEPTH];

  mini_imem_boot_rom #(
    .IW(IW),
    .AW(AW)
  ) u_boot_rom (
    .addr(cnt_q),
    .word(rom_word)
  );

  assign init_last      = (state_q == S_INIT) && (cnt_q == AW'(DEPTH - 1));
  assign fetch_acc      = fetch_req && fetch_ready;
  assign fetch_in_range = 32'(fetch_addr) < DEPTH;
  assign prog_in_range  = 32'(prog_addr) < DEPTH;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and mode outputs
  always_comb begin
    state_d     = state_q;
    fetch_ready = 1'b0;
    busy        = 1'b1;
    case (state_q)
      S_INIT: begin
        if (init_last) state_d = S_RUN;
      end
      S_RUN: begin
        fetch_ready = 1'b1;
        busy        = 1'b0;
        if (prog_en) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!prog_en) state_d = S_RUN;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Init counter walks every word once; boot_done latches on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      boot_done <= 1'b0;
    end else begin
      if (state_q == S_INIT) cnt_q <= cnt_q + AW'(1);
      if (init_last)         boot_done <= 1'b1;
    end
  end

  // Write port mux: INIT images the boot program, LOAD takes host writes.
  // Out-of-range host writes are dropped rather than aliased.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = rom_word;
    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = (32'(cnt_q) < BOOT_LEN) ? rom_word : IW'(NOP);
      end
      S_LOAD: begin
        mem_we    = prog_we && prog_in_range;
        mem_waddr = prog_addr;
        mem_wdata = prog_data;
      end
      default: mem_we = 1'b0;
    endcase
  end

  // RAM array has no reset; it is rebuilt by INIT instead.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read path; fetch_data holds when no fetch is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_data  <= IW'(NOP);
    end else if (fetch_acc) begin
      fetch_valid <= 1'b1;
      if (fetch_in_range) begin
        fetch_err  <= 1'b0;
        fetch_data <= mem[fetch_addr];
      end else begin
        fetch_err  <= 1'b1;
        fetch_data <= IW'(NOP);
      end
    end else begin
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end
  end

endmodule
